packed_array_assembler: RTL

// - Writer side of the packed-array parameter path: assembles a [OUTER][INNER][ELEM_W] packed frame

---
 rtl/packed_array_pkg.sv | 23 ++
 rtl/packed_index_counter.sv | 48 ++++
 rtl/packed_array_assembler.sv | 95 +++++++++
 3 files changed

// File: rtl/packed_array_pkg.sv
// Shared types and defaults for the packed-array frame assembler.
// Frame layout matches a packed parameter [OUTER][INNER][ELEM_W].
package packed_array_pkg;

  localparam int OUTER_D  = 2;
  localparam int INNER_D  = 3;
  localparam int ELEM_W_D = 4;

  typedef logic [ELEM_W_D-1:0] elem_t;
  typedef elem_t [INNER_D-1:0] row_t;
  typedef row_t [OUTER_D-1:0]  frame_t;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } asm_state_e;

  // Index width for n entries; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/packed_index_counter.sv
// Two-level (row, column) wrap counter for the frame fill position.
// last flags the final slot [OUTER-1][INNER-1].
module packed_index_counter
  import packed_array_pkg::*;
#(
  parameter int OUTER = OUTER_D,
  parameter int INNER = INNER_D,
  parameter int OW    = idx_w(OUTER),
  parameter int IW    = idx_w(INNER)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [OW-1:0] o,
  output logic [IW-1:0] i,
  output logic          last
);

  localparam logic [OW-1:0] OMAX = OW'(OUTER - 1);
  localparam logic [IW-1:0] IMAX = IW'(INNER - 1);

  logic o_end;
  logic i_end;

  assign o_end = (o == OMAX);
  assign i_end = (i == IMAX);
  assign last  = o_end && i_end;

  // Advance column, carrying into row; both wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o <= '0;
      i <= '0;
    end else if (clr) begin
      o <= '0;
      i <= '0;
    end else if (inc) begin
      if (i_end) begin
        i <= '0;
        o <= o_end ? '0 : o + 1'b1;
      end else begin
        i <= i + 1'b1;
      end
    end
  end

endmodule

// File: rtl/packed_array_assembler.sv
// Assembles a packed [OUTER][INNER][ELEM_W] frame from a serial
// element stream and presents it with a valid/ready handshake.
module packed_array_assembler
  import packed_array_pkg::*;
#(
  parameter int OUTER  = OUTER_D,
  parameter int INNER  = INNER_D,
  parameter int ELEM_W = ELEM_W_D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUTER-1:0][INNER-1:0][ELEM_W-1:0] out_data,
  output logic [7:0]        frame_cnt
);

  localparam int OW = idx_w(OUTER);
  localparam int IW = idx_w(INNER);

  asm_state_e    state;
  logic [OW-1:0] o;
  logic [IW-1:0] i;
  logic          last;
  logic          accept;

  assign accept = in_valid && in_ready
               && (state == FILL) && !flush;

  packed_index_counter #(
    .OUTER(OUTER),
    .INNER(INNER),
    .OW   (OW),
    .IW   (IW)
  ) u_idx (
    .clk (clk),
    .rst (rst),
    .inc (accept),
    .clr (flush),
    .o   (o),
    .i   (i),
    .last(last)
  );

  // Write each accepted element into its slot; old slots persist.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else if (accept) begin
      out_data[o][i] <= in_data;
    end
  end

  // Fill/hold FSM with registered handshake outputs and frame count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      frame_cnt <= '0;
    end else if (flush) begin
      state     <= FILL;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        FILL: begin
          if (accept && last) begin
            state     <= HOLD;
            in_ready  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= FILL;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
          end
        end
        default: begin
          state     <= FILL;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
